multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: drives datapath selects per state, memory waits on mem_ready.
// Ports: clk, reset_n (sync, active-low), opcode, mem_ready -> datapath controls, instr_done, state_dbg. Option: MC_ILLEGAL_TRAP_EN.
module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    IDLE      = STATE_W'(0),
    FETCH     = STATE_W'(1),
    DECODE    = STATE_W'(2),
    MEM_ADDR  = STATE_W'(3),
    MEM_RD    = STATE_W'(4),
    MEM_WB    = STATE_W'(5),
    MEM_WR    = STATE_W'(6),
    R_EXEC    = STATE_W'(7),
    R_WB      = STATE_W'(8),
    ADDI_EXEC = STATE_W'(9),
    ADDI_WB   = STATE_W'(10),
    BRANCH    = STATE_W'(11),
    JUMP      = STATE_W'(12)
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP    = STATE_W'(13)
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state;
  state_t next;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  assign state_dbg = state;

  always_comb begin
    next        = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R:         next = R_EXEC;
          OP_LW, OP_SW: next = MEM_ADDR;
          OP_BEQ:       next = BRANCH;
          OP_J:         next = JUMP;
          OP_ADDI:      next = ADDI_EXEC;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            next = TRAP;
`else
            next       = FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // lw and sw differ only in opcode bit 3
        next = opcode[3] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) next = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        next       = FETCH;
      end
      MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next = FETCH;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        next    = R_WB;
      end
      R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next       = FETCH;
      end
      ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        next    = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next       = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        next        = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        next       = FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: next = TRAP;
`endif
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a reference model queues expected
// state/outputs per driven cycle; a monitor pops and compares them.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       instr_done;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .instr_done(instr_done), .state_dbg(state_dbg)
  );

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2;
  localparam logic [3:0] S_MA = 4'd3, S_MRD = 4'd4, S_MWB = 4'd5;
  localparam logic [3:0] S_MWR = 4'd6, S_REX = 4'd7, S_RWB = 4'd8;
  localparam logic [3:0] S_AEX = 4'd9, S_AWB = 4'd10, S_BR = 4'd11;
  localparam logic [3:0] S_J = 4'd12, S_TRAP = 4'd13;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] m;

  wire [16:0] obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                     MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
                     ALUOp, ALUSrcB, PCSource, instr_done};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic known(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // Order: PCW PCWC IorD MR MW M2R IRW SrcA RW RDst | ALUOp SrcB PCSrc | done
  function automatic logic [16:0] outs(input logic [3:0] s, input logic r,
                                       input logic [5:0] op);
    logic dn;
`ifdef MC_ILLEGAL_TRAP_EN
    dn = 1'b0;
`else
    dn = !known(op);
`endif
    case (s)
      S_FETCH: return {r, 5'b00100, r, 3'b000, 6'b000100, 1'b0};
      S_DEC:   return {10'b0, 6'b001100, dn};
      S_MA:    return {10'b0000000100, 6'b001000, 1'b0};
      S_MRD:   return {10'b0011000000, 6'b000000, 1'b0};
      S_MWB:   return {10'b0000010010, 6'b000000, 1'b1};
      S_MWR:   return {10'b0010100000, 6'b000000, r};
      S_REX:   return {10'b0000000100, 6'b100000, 1'b0};
      S_RWB:   return {10'b0000000011, 6'b000000, 1'b1};
      S_AEX:   return {10'b0000000100, 6'b111000, 1'b0};
      S_AWB:   return {10'b0000000010, 6'b000000, 1'b1};
      S_BR:    return {10'b0100000100, 6'b010001, 1'b1};
      S_J:     return {10'b1000000000, 6'b000010, 1'b1};
      default: return 17'b0;
    endcase
  endfunction

  function automatic logic [3:0] nxt(input logic [3:0] s, input logic r,
                                     input logic [5:0] op);
    case (s)
      S_IDLE:  return S_FETCH;
      S_FETCH: return r ? S_DEC : S_FETCH;
      S_DEC: begin
        if (op == 6'b000000) return S_REX;
        if (op == 6'b100011 || op == 6'b101011) return S_MA;
        if (op == 6'b000100) return S_BR;
        if (op == 6'b000010) return S_J;
        if (op == 6'b001000) return S_AEX;
`ifdef MC_ILLEGAL_TRAP_EN
        return S_TRAP;
`else
        return S_FETCH;
`endif
      end
      S_MA:    return (op == 6'b100011) ? S_MRD : S_MWR;
      S_MRD:   return r ? S_MWB : S_MRD;
      S_MWR:   return r ? S_FETCH : S_MWR;
      S_REX:   return S_RWB;
      S_AEX:   return S_AWB;
      S_TRAP:  return S_TRAP;
      default: return S_FETCH;
    endcase
  endfunction

  task automatic step(input logic rn, input logic [5:0] op, input logic r);
    exp_t e;
    @(negedge clk);
    reset_n   = rn;
    opcode    = op;
    mem_ready = r;
    e.st = m;
    e.o  = outs(m, r, op);
    q.push_back(e);
    m = rn ? nxt(m, r, op) : S_IDLE;
  endtask

  task automatic run(input logic [5:0] op, input logic r, input int n);
    for (int i = 0; i < n; i++) step(1'b1, op, r);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(state_dbg), 32'(e.st));
      chk("outs", 32'(obs), 32'(e.o));
    end
  end

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    m = S_IDLE;
    step(1'b0, 6'b000000, 1'b1);
    step(1'b0, 6'b000000, 1'b1);
    // R-type: IDLE FETCH DECODE R_EXEC R_WB
    run(6'b000000, 1'b1, 5);
    // lw with fetch wait, then MEM_RD held 4 cycles; opcode wiggles in MEM_RD
    run(6'b100011, 1'b0, 2);
    run(6'b100011, 1'b1, 3);
    run(6'b000100, 1'b0, 3);
    run(6'b100011, 1'b1, 2);
    // sw with two wait cycles
    run(6'b101011, 1'b1, 3);
    run(6'b101011, 1'b0, 2);
    run(6'b101011, 1'b1, 1);
    // addi, beq, j
    run(6'b001000, 1'b1, 4);
    run(6'b000100, 1'b1, 3);
    run(6'b000010, 1'b1, 3);
    // R-type with opcode changed after DECODE
    run(6'b000000, 1'b1, 2);
    run(6'b101011, 1'b1, 2);
    // illegal opcode: NOP back to FETCH, or TRAP held
    run(6'b111111, 1'b1, 5);
    // reset during a stalled MEM_WR
    step(1'b0, 6'b101011, 1'b1);
    run(6'b101011, 1'b1, 4);
    step(1'b0, 6'b101011, 1'b0);
    run(6'b101011, 1'b0, 2);
    run(6'b000010, 1'b1, 4);
    @(negedge clk);
    #5;
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
